// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader that writes 32-bit little-endian words
// into instruction memory and holds the core until the image checksum is verified.
module imem_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  input  logic              load_req_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              core_hold_o,
  output logic              load_done_o,
  output logic              load_err_o
);
  localparam int IW = ADDR_W + 1;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, ERR} state_e;
  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d, csum_q, csum_d;
  logic [IW-1:0]     len_q, len_d, idx_q, idx_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       wd_q, wd_d;
  logic              we_q, we_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              beat, too_big;
  assign in_ready_o  = state_q inside {LEN0, LEN1, DATA, CSUM};
  assign beat        = in_valid_i & in_ready_o;
  assign too_big     = 32'({in_data_i, len_lo_q}) > (32'd1 << ADDR_W);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign core_hold_o = hold_q;
  assign load_done_o = done_q;
  assign load_err_o  = err_q;
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    csum_d   = csum_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      IDLE, ERR: if (load_req_i) begin
        state_d = LEN0;
        hold_d  = 1'b1;
        done_d  = 1'b0;
        err_d   = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
        csum_d  = '0;
      end
      LEN0: if (beat) begin
        len_lo_d = in_data_i;
        state_d  = LEN1;
      end
      LEN1: if (beat) begin
        len_d   = IW'({in_data_i, len_lo_q});
        err_d   = too_big;
        state_d = too_big ? ERR : ({in_data_i, len_lo_q} == 16'd0) ? CSUM : DATA;
      end
      DATA: if (beat) begin
        csum_d = csum_q ^ in_data_i;
        cnt_d  = cnt_q + 2'd1;
        wd_d   = {in_data_i, wd_q[23:8]};
        if (cnt_q == 2'd3) begin
          we_d    = 1'b1;
          addr_d  = ADDR_W'(BASE_ADDR) + idx_q[ADDR_W-1:0];
          wdata_d = {in_data_i, wd_q};
          idx_d   = idx_q + IW'(1);
          state_d = (idx_q + IW'(1) == len_q) ? CSUM : DATA;
        end
      end
      CSUM: if (beat) begin
        done_d  = in_data_i == csum_q;
        err_d   = in_data_i != csum_q;
        hold_d  = in_data_i != csum_q;
        state_d = (in_data_i == csum_q) ? IDLE : ERR;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LEN0;
      len_lo_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      wd_q     <= '0;
      csum_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      csum_q   <= csum_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: two loaders (10-bit/base 0 and 4-bit/base 14) checked every cycle
// against a frame-level model built from the received byte list.
module tb_imem_loader;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [1:0]  vld = '0, req = '0;
  logic [7:0]  dat [2];
  logic [1:0]  rdy, we, hold, done, err;
  logic [9:0]  addr_a;
  logic [3:0]  addr_b;
  logic [31:0] wd_a, wd_b;
  int          checks = 0, errs = 0;
  bit          m_act [2] = '{1'b1, 1'b1};
  bit          m_we [2] = '{1'b0, 1'b0};
  bit          m_hold [2] = '{1'b1, 1'b1};
  bit          m_done [2] = '{1'b0, 1'b0};
  bit          m_err [2] = '{1'b0, 1'b0};
  int          m_nb [2] = '{0, 0};
  int          m_n [2] = '{0, 0};
  int          m_nw [2] = '{0, 0};
  int          d_nw [2] = '{0, 0};
  logic [31:0] m_addr [2], m_wd [2];
  logic [7:0]  fb [2][256];
  logic [31:0] m_log_a [2][64], m_log_d [2][64], d_log_a [2][64], d_log_d [2][64];
  logic [7:0]  fq [$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(10), .BASE_ADDR(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid_i(vld[0]), .in_data_i(dat[0]), .in_ready_o(rdy[0]),
    .load_req_i(req[0]), .mem_we_o(we[0]), .mem_addr_o(addr_a), .mem_wdata_o(wd_a),
    .core_hold_o(hold[0]), .load_done_o(done[0]), .load_err_o(err[0]));
  imem_loader #(.ADDR_W(4), .BASE_ADDR(14)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid_i(vld[1]), .in_data_i(dat[1]), .in_ready_o(rdy[1]),
    .load_req_i(req[1]), .mem_we_o(we[1]), .mem_addr_o(addr_b), .mem_wdata_o(wd_b),
    .core_hold_o(hold[1]), .load_done_o(done[1]), .load_err_o(err[1]));

  function automatic int aw(input int i);
    return i == 0 ? 10 : 4;
  endfunction
  function automatic int base(input int i);
    return i == 0 ? 0 : 14;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Frame semantics from the byte count: bytes 0-1 are the length, then 4N payload, then CSUM.
  task automatic model_beat(input int i, input logic [7:0] b);
    int k;
    logic [7:0] x;
    fb[i][m_nb[i]] = b;
    m_nb[i]++;
    k = m_nb[i];
    if (k == 2) begin
      m_n[i] = int'({fb[i][1], fb[i][0]});
      if (m_n[i] > (1 << aw(i))) begin
        m_err[i] = 1'b1;
        m_act[i] = 1'b0;
      end
    end else if (k > 2 && k <= 4 * m_n[i] + 2) begin
      if ((k - 2) % 4 == 0) begin
        m_we[i] = 1'b1;
        m_addr[i] = 32'((base(i) + (k - 2) / 4 - 1) % (1 << aw(i)));
        m_wd[i] = {fb[i][k-1], fb[i][k-2], fb[i][k-3], fb[i][k-4]};
        m_log_a[i][m_nw[i]] = m_addr[i];
        m_log_d[i][m_nw[i]] = m_wd[i];
        m_nw[i]++;
      end
    end else if (k == 4 * m_n[i] + 3) begin
      x = 8'h00;
      for (int j = 2; j < k - 1; j++) x ^= fb[i][j];
      m_done[i] = x == b;
      m_err[i]  = x != b;
      m_hold[i] = x != b;
      m_act[i]  = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b1; m_nb[i] = 0; m_we[i] = 1'b0;
        m_hold[i] = 1'b1; m_done[i] = 1'b0; m_err[i] = 1'b0;
      end else begin
        m_we[i] = 1'b0;
        if (!m_act[i]) begin
          if (req[i]) begin
            m_act[i] = 1'b1; m_nb[i] = 0;
            m_done[i] = 1'b0; m_err[i] = 1'b0; m_hold[i] = 1'b1;
          end
        end else if (vld[i]) model_beat(i, dat[i]);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(m_act[i]));
      chk($sformatf("mem_we[%0d]", i), 32'(we[i]), 32'(m_we[i]));
      chk($sformatf("core_hold[%0d]", i), 32'(hold[i]), 32'(m_hold[i]));
      chk($sformatf("load_done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
      chk($sformatf("load_err[%0d]", i), 32'(err[i]), 32'(m_err[i]));
      if (m_we[i]) begin
        chk($sformatf("mem_addr[%0d]", i), i == 0 ? 32'(addr_a) : 32'(addr_b), m_addr[i]);
        chk($sformatf("mem_wdata[%0d]", i), i == 0 ? wd_a : wd_b, m_wd[i]);
      end
      if (we[i] && d_nw[i] < 64) begin
        d_log_a[i][d_nw[i]] = i == 0 ? 32'(addr_a) : 32'(addr_b);
        d_log_d[i][d_nw[i]] = i == 0 ? wd_a : wd_b;
        d_nw[i]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input int gap);
    foreach (fq[k]) begin
      vld[i] = 1'b1;
      dat[i] = fq[k];
      tick(1);
      vld[i] = 1'b0;
      tick(gap);
    end
  endtask

  task automatic pulse_req(input int i);
    req[i] = 1'b1;
    tick(1);
    req[i] = 1'b0;
  endtask

  task automatic chk_reset(input int i);
    chk($sformatf("rst in_ready[%0d]", i), 32'(rdy[i]), 32'd1);
    chk($sformatf("rst core_hold[%0d]", i), 32'(hold[i]), 32'd1);
    chk($sformatf("rst mem_we[%0d]", i), 32'(we[i]), 32'd0);
    chk($sformatf("rst mem_addr[%0d]", i), i == 0 ? 32'(addr_a) : 32'(addr_b), 32'd0);
    chk($sformatf("rst mem_wdata[%0d]", i), i == 0 ? wd_a : wd_b, 32'd0);
    chk($sformatf("rst load_done[%0d]", i), 32'(done[i]), 32'd0);
    chk($sformatf("rst load_err[%0d]", i), 32'(err[i]), 32'd0);
  endtask

  initial begin
    logic [7:0] x;
    dat[0] = 8'h00;
    dat[1] = 8'h00;
    #1 rst_n = 1'b0;
    #2 chk_reset(0);
    chk_reset(1);
    #9 rst_n = 1'b1;
    tick(1);
    // Nominal image; XOR of the payload 13^93^10 is 0x90.
    fq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send(0, 0);
    tick(2);
    chk("nominal done", 32'(done[0]), 32'd1);
    chk("nominal hold", 32'(hold[0]), 32'd0);
    chk("nominal writes", 32'(d_nw[0]), 32'd2);
    chk("nominal w0 addr", d_log_a[0][0], 32'd0);
    chk("nominal w0 data", d_log_d[0][0], 32'h00000013);
    chk("nominal w1 addr", d_log_a[0][1], 32'd1);
    chk("nominal w1 data", d_log_d[0][1], 32'h00100093);
    chk("model w1 data", m_log_d[0][1], 32'h00100093);
    pulse_req(0);
    send(0, 1);
    tick(2);
    chk("gapped done", 32'(done[0]), 32'd1);
    chk("gapped writes", 32'(d_nw[0]), 32'd4);
    chk("gapped w0 data", d_log_d[0][2], 32'h00000013);
    chk("gapped w1 addr", d_log_a[0][3], 32'd1);
    chk("gapped w1 data", d_log_d[0][3], 32'h00100093);
    pulse_req(0);
    fq = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
    send(0, 0);
    tick(2);
    chk("badcsum err", 32'(err[0]), 32'd1);
    chk("badcsum hold", 32'(hold[0]), 32'd1);
    chk("badcsum writes", 32'(d_nw[0]), 32'd5);
    pulse_req(0);
    chk("restart err", 32'(err[0]), 32'd0);
    chk("restart ready", 32'(rdy[0]), 32'd1);
    fq = '{8'h00, 8'h00, 8'h00};
    send(0, 0);
    tick(2);
    chk("empty done", 32'(done[0]), 32'd1);
    chk("empty writes", 32'(d_nw[0]), 32'd5);
    fq = '{8'h11, 8'h00};
    send(1, 0);
    tick(3);
    chk("overflow err", 32'(err[1]), 32'd1);
    chk("overflow ready", 32'(rdy[1]), 32'd0);
    chk("overflow writes", 32'(d_nw[1]), 32'd0);
    pulse_req(1);
    fq = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
           8'h09, 8'h0a, 8'h0b, 8'h0c, 8'h0c};
    send(1, 0);
    tick(2);
    chk("wrap done", 32'(done[1]), 32'd1);
    chk("wrap a0", d_log_a[1][0], 32'd14);
    chk("wrap a1", d_log_a[1][1], 32'd15);
    chk("wrap a2", d_log_a[1][2], 32'd0);
    chk("wrap d2", d_log_d[1][2], 32'h0c0b0a09);
    chk("model wrap a2", m_log_a[1][2], 32'd0);
    pulse_req(1);
    fq = '{8'h10, 8'h00};
    x = 8'h00;
    for (int k = 0; k < 64; k++) begin
      fq.push_back(8'(k * 7 + 5));
      x ^= 8'(k * 7 + 5);
    end
    fq.push_back(x);
    send(1, 0);
    tick(2);
    chk("full done", 32'(done[1]), 32'd1);
    chk("full writes", 32'(d_nw[1]), 32'd19);
    chk("full last addr", d_log_a[1][18], 32'd13);
    pulse_req(1);
    fq = '{8'h02, 8'h00, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};
    send(1, 0);
    chk("pre-reset addr", 32'(addr_b), 32'd14);
    #2 rst_n = 1'b0;
    #1 chk_reset(1);
    chk_reset(0);
    #3 rst_n = 1'b1;
    tick(1);
    fq = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send(1, 0);
    tick(2);
    chk("fresh done", 32'(done[1]), 32'd1);
    chk("fresh writes", 32'(d_nw[1]), 32'd21);
    chk("fresh addr", d_log_a[1][20], 32'd14);
    chk("fresh data", d_log_d[1][20], 32'h44332211);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
